// File: rtl/ctrl_fsm_core.sv
// Flash playback controller: walks word addresses start..finish, reads each word,
// and plays its four bytes LSB-first as audio samples, one per sync rising edge.
module ctrl_fsm_core (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start_from_pico,
    input  logic [23:0] start_addr,
    input  logic [23:0] finish_addr,
    input  logic        play,
    input  logic        sync,
    input  logic        done_read,
    input  logic [31:0] data_in_read,
    output logic        start_flag,
    output logic [23:0] addr,
    output logic [7:0]  flash_data_audio,
    output logic        finish_to_pico
);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WAIT_READ,
        WAIT_SYNC,
        NEXT,
        DONE
    } state_t;

    state_t      state_reg;
    logic [31:0] word_reg;
    logic [1:0]  idx_reg;
    logic [23:0] end_reg;
    logic        sync_d_reg;
    logic        sync_rise;
    logic [7:0]  byte_sel;

    // A sync held high only ever claims one sample slot.
    assign sync_rise = sync & ~sync_d_reg;
    assign byte_sel  = word_reg[{idx_reg, 3'b000} +: 8];

    // start_flag and finish_to_pico are set on entry to READ / DONE so each
    // is high for exactly the one cycle spent in that state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg        <= IDLE;
            addr             <= 24'd0;
            flash_data_audio <= 8'd0;
            start_flag       <= 1'b0;
            finish_to_pico   <= 1'b0;
            word_reg         <= 32'd0;
            idx_reg          <= 2'd0;
            end_reg          <= 24'd0;
            sync_d_reg       <= 1'b0;
        end else begin
            sync_d_reg     <= sync;
            start_flag     <= 1'b0;
            finish_to_pico <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start_from_pico && play) begin
                        addr       <= start_addr;
                        end_reg    <= finish_addr;
                        start_flag <= 1'b1;
                        state_reg  <= READ;
                    end
                end
                READ: begin
                    state_reg <= WAIT_READ;
                end
                WAIT_READ: begin
                    if (done_read) begin
                        word_reg  <= data_in_read;
                        idx_reg   <= 2'd0;
                        state_reg <= WAIT_SYNC;
                    end
                end
                WAIT_SYNC: begin
                    // play=0 freezes everything; sync edges during pause are dropped.
                    if (sync_rise && play) begin
                        flash_data_audio <= byte_sel;
                        idx_reg          <= idx_reg + 2'd1;
                        if (idx_reg == 2'd3) begin
                            state_reg <= NEXT;
                        end
                    end
                end
                NEXT: begin
                    // >= also terminates a reversed range after its first word.
                    if (addr >= end_reg) begin
                        finish_to_pico <= 1'b1;
                        state_reg      <= DONE;
                    end else begin
                        addr       <= addr + 24'd1;
                        start_flag <= 1'b1;
                        state_reg  <= READ;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ctrl_fsm_core.sv
// Directed bench for ctrl_fsm_core: acts as Pico, flash reader and audio sync source.
module tb_ctrl_fsm_core;

    logic        clk;
    logic        reset_n;
    logic        start_from_pico;
    logic [23:0] start_addr;
    logic [23:0] finish_addr;
    logic        play;
    logic        sync;
    logic        done_read;
    logic [31:0] data_in_read;
    logic        start_flag;
    logic [23:0] addr;
    logic [7:0]  flash_data_audio;
    logic        finish_to_pico;

    int errors = 0;
    int checks = 0;

    ctrl_fsm_core dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .start_from_pico  (start_from_pico),
        .start_addr       (start_addr),
        .finish_addr      (finish_addr),
        .play             (play),
        .sync             (sync),
        .done_read        (done_read),
        .data_in_read     (data_in_read),
        .start_flag       (start_flag),
        .addr             (addr),
        .flash_data_audio (flash_data_audio),
        .finish_to_pico   (finish_to_pico)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_seg(input logic [23:0] s, input logic [23:0] f);
        start_addr      = s;
        finish_addr     = f;
        start_from_pico = 1'b1;
        step();
        start_from_pico = 1'b0;
        chk("start_latency", {31'd0, start_flag}, 32'd1);
    endtask

    task automatic pulse_sync();
        sync = 1'b1;
        step();
        sync = 1'b0;
        step();
    endtask

    task automatic wait_start();
        int n = 0;
        while (start_flag !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk("start_flag_seen", {31'd0, start_flag}, 32'd1);
    endtask

    task automatic serve_read(input logic [23:0] exp_addr, input logic [31:0] data);
        wait_start();
        chk("read_addr", {8'd0, addr}, {8'd0, exp_addr});
        step();
        chk("start_flag_one_cycle", {31'd0, start_flag}, 32'd0);
        done_read    = 1'b1;
        data_in_read = data;
        step();
        done_read    = 1'b0;
        data_in_read = 32'd0;
    endtask

    task automatic play_word(input logic [23:0] exp_addr, input logic [31:0] data);
        logic [31:0] d;
        serve_read(exp_addr, data);
        d = data;
        for (int b = 0; b < 4; b++) begin
            pulse_sync();
            chk($sformatf("sample_a%0h_b%0d", exp_addr, b), {24'd0, flash_data_audio}, {24'd0, d[8*b +: 8]});
        end
    endtask

    task automatic wait_finish();
        int n = 0;
        while (finish_to_pico !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk("finish_seen", {31'd0, finish_to_pico}, 32'd1);
        step();
        chk("finish_one_cycle", {31'd0, finish_to_pico}, 32'd0);
    endtask

    initial begin
        int seen;
        reset_n         = 1'b0;
        start_from_pico = 1'b0;
        start_addr      = 24'd0;
        finish_addr     = 24'd0;
        play            = 1'b0;
        sync            = 1'b0;
        done_read       = 1'b0;
        data_in_read    = 32'd0;
        repeat (3) step();
        reset_n = 1'b1;
        step();

        // Reset values, then idle with play=1 and no start.
        chk("rst_addr", {8'd0, addr}, 32'd0);
        chk("rst_audio", {24'd0, flash_data_audio}, 32'd0);
        chk("rst_start_flag", {31'd0, start_flag}, 32'd0);
        chk("rst_finish", {31'd0, finish_to_pico}, 32'd0);
        play = 1'b1;
        repeat (5) step();
        chk("idle_static_sf", {31'd0, start_flag}, 32'd0);
        chk("idle_static_addr", {8'd0, addr}, 32'd0);

        // Start with play=0 is ignored.
        play            = 1'b0;
        start_addr      = 24'h7;
        finish_addr     = 24'h7;
        start_from_pico = 1'b1;
        repeat (3) step();
        start_from_pico = 1'b0;
        chk("start_nopl_sf", {31'd0, start_flag}, 32'd0);
        chk("start_nopl_addr", {8'd0, addr}, 32'd0);
        play = 1'b1;

        // Single word.
        start_seg(24'h10, 24'h10);
        play_word(24'h10, 32'h44332211);
        wait_finish();
        chk("addr_hold_after_done", {8'd0, addr}, 32'h10);
        chk("audio_hold_after_done", {24'd0, flash_data_audio}, 32'h44);

        // Multi-word 1..3: no completion before the 12th sample.
        start_seg(24'h1, 24'h3);
        play_word(24'h1, 32'h0D0C0B0A);
        chk("multi_no_early_finish1", {31'd0, finish_to_pico}, 32'd0);
        play_word(24'h2, 32'h1D1C1B1A);
        chk("multi_no_early_finish2", {31'd0, finish_to_pico}, 32'd0);
        play_word(24'h3, 32'h2D2C2B2A);
        wait_finish();

        // Pause after 2nd sample; sync edges during pause are dropped.
        start_seg(24'h30, 24'h30);
        serve_read(24'h30, 32'hAABBCCDD);
        pulse_sync();
        chk("pause_b0", {24'd0, flash_data_audio}, 32'hDD);
        pulse_sync();
        chk("pause_b1", {24'd0, flash_data_audio}, 32'hCC);
        play = 1'b0;
        repeat (5) pulse_sync();
        chk("pause_audio_hold", {24'd0, flash_data_audio}, 32'hCC);
        chk("pause_addr_hold", {8'd0, addr}, 32'h30);
        play = 1'b1;
        step();
        pulse_sync();
        chk("resume_b2", {24'd0, flash_data_audio}, 32'hBB);
        pulse_sync();
        chk("resume_b3", {24'd0, flash_data_audio}, 32'hAA);
        wait_finish();

        // Sync held high counts once; stray done_read in WAIT_SYNC is ignored.
        start_seg(24'h40, 24'h41);
        serve_read(24'h40, 32'h04030201);
        pulse_sync();
        chk("held_b0", {24'd0, flash_data_audio}, 32'h01);
        done_read    = 1'b1;
        data_in_read = 32'hDEADBEEF;
        step();
        done_read    = 1'b0;
        data_in_read = 32'd0;
        chk("stray_done_audio", {24'd0, flash_data_audio}, 32'h01);
        sync = 1'b1;
        repeat (10) step();
        chk("held_one_advance", {24'd0, flash_data_audio}, 32'h02);
        sync = 1'b0;
        step();
        pulse_sync();
        chk("held_b2", {24'd0, flash_data_audio}, 32'h03);
        pulse_sync();
        chk("held_b3", {24'd0, flash_data_audio}, 32'h04);
        play_word(24'h41, 32'h88776655);
        wait_finish();

        // Reversed range: only start_addr is played.
        start_seg(24'h25, 24'h20);
        play_word(24'h25, 32'hC3C2C1C0);
        wait_finish();
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            if (start_flag === 1'b1) seen++;
            step();
        end
        chk("reverse_no_second_read", seen, 32'd0);
        chk("reverse_addr_hold", {8'd0, addr}, 32'h25);

        // Abort during WAIT_READ.
        start_seg(24'h50, 24'h52);
        wait_start();
        step();
        reset_n = 1'b0;
        #2;
        chk("abort_addr", {8'd0, addr}, 32'd0);
        chk("abort_audio", {24'd0, flash_data_audio}, 32'd0);
        chk("abort_start_flag", {31'd0, start_flag}, 32'd0);
        step();
        reset_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            if (finish_to_pico === 1'b1 || start_flag === 1'b1) seen++;
            step();
        end
        chk("abort_no_finish", seen, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
